// File: rtl/mips_ctrl_pkg.sv
// Shared opcode/ALU encodings, bundle field layout and decode flags for the pipelined control block.
package mips_ctrl_pkg;

   localparam logic [5:0] ADD_op  = 6'h20;
   localparam logic [5:0] SUB_op  = 6'h22;
   localparam logic [5:0] MUL_op  = 6'h18;
   localparam logic [5:0] AND_op  = 6'h24;
   localparam logic [5:0] OR_op   = 6'h25;
   localparam logic [5:0] ADDI_op = 6'h08;
   localparam logic [5:0] LW_op   = 6'h23;
   localparam logic [5:0] SW_op   = 6'h2B;
   localparam logic [5:0] J_op    = 6'h02;
   localparam logic [5:0] BEQ_op  = 6'h04;

   // ALU codes are nonzero so a real instruction is distinguishable from a bubble in EX.
   localparam logic [2:0] ADD_alu = 3'd1;
   localparam logic [2:0] SUB_alu = 3'd2;
   localparam logic [2:0] MUL_alu = 3'd3;
   localparam logic [2:0] AND_alu = 3'd4;
   localparam logic [2:0] OR_alu  = 3'd5;

   localparam int MEM_W      = 2;
   localparam int WB_W       = 2;
   localparam int MEM_CS_BIT = 1;
   localparam int MEM_WE_BIT = 0;
   localparam int WB_MUX_BIT = 1;
   localparam int WB_WE_BIT  = 0;

   typedef struct packed {
      logic illegal;
      logic reads_rt;
      logic is_load;
      logic is_mul;
   } dec_flags_t;

endpackage

// File: rtl/pipeline_control_decode.sv
// Combinational opcode decoder: EX/MEM/WB bundles plus hazard-relevant flags.
module control_decode
   import mips_ctrl_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int ALUOP_W = 3
) (
   input  logic [OP_W-1:0]    op_i,
   output logic [ALUOP_W+1:0] ex_o,
   output logic [MEM_W-1:0]   mem_o,
   output logic [WB_W-1:0]    wb_o,
   output dec_flags_t         flags_o
);

   logic               r_type;
   logic [ALUOP_W-1:0] r_alu;

   always_comb begin
      r_type = 1'b1;
      r_alu  = '0;
      case (op_i)
         OP_W'(ADD_op): r_alu = ALUOP_W'(ADD_alu);
         OP_W'(SUB_op): r_alu = ALUOP_W'(SUB_alu);
         OP_W'(MUL_op): r_alu = ALUOP_W'(MUL_alu);
         OP_W'(AND_op): r_alu = ALUOP_W'(AND_alu);
         OP_W'(OR_op):  r_alu = ALUOP_W'(OR_alu);
         default:       r_type = 1'b0;
      endcase
   end

   always_comb begin
      ex_o    = '0;
      mem_o   = '0;
      wb_o    = '0;
      flags_o = '0;
      if (r_type) begin
         ex_o                = {r_alu, 1'b0, 1'b1};
         wb_o[WB_MUX_BIT]    = 1'b1;
         wb_o[WB_WE_BIT]     = 1'b1;
         flags_o.reads_rt    = 1'b1;
         flags_o.is_mul      = (op_i == OP_W'(MUL_op));
      end else begin
         case (op_i)
            OP_W'(ADDI_op): begin
               ex_o             = {ALUOP_W'(ADD_alu), 1'b1, 1'b0};
               wb_o[WB_MUX_BIT] = 1'b1;
               wb_o[WB_WE_BIT]  = 1'b1;
            end
            OP_W'(LW_op): begin
               ex_o               = {ALUOP_W'(ADD_alu), 1'b1, 1'b0};
               mem_o[MEM_CS_BIT]  = 1'b1;
               wb_o[WB_WE_BIT]    = 1'b1;
               flags_o.is_load    = 1'b1;
            end
            OP_W'(SW_op): begin
               ex_o               = {ALUOP_W'(ADD_alu), 1'b1, 1'b0};
               mem_o[MEM_CS_BIT]  = 1'b1;
               mem_o[MEM_WE_BIT]  = 1'b1;
               flags_o.reads_rt   = 1'b1;
            end
            OP_W'(J_op):   ;
            OP_W'(BEQ_op): flags_o.reads_rt = 1'b1;
            default:       flags_o.illegal  = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/pipeline_control.sv
// Pipelined control: ID/EX, EX/MEM, MEM/WB control registers (1/2/3-cycle latency), load-use and MUL stalls,
// jump/branch redirect. Front end is held through pc_we_o/ifid_we_o; MUL stall outranks load-use outranks redirect.
module pipeline_control
   import mips_ctrl_pkg::*;
#(
   parameter int OP_W       = 6,
   parameter int ALUOP_W    = 3,
   parameter int REG_AW     = 5,
   parameter int MUL_CYCLES = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [OP_W-1:0]      op_i,
   input  logic [REG_AW-1:0]    id_rs_i,
   input  logic [REG_AW-1:0]    id_rt_i,
   input  logic                 is_equal_i,
   output logic [1:0]           PC_ctrl_o,
   output logic                 pc_we_o,
   output logic                 ifid_we_o,
   output logic                 ifid_flush_o,
   output logic [ALUOP_W+1:0]   EX_ctrl_o,
   output logic [MEM_W-1:0]     MEM_ctrl_o,
   output logic [WB_W-1:0]      WB_ctrl_o,
   output logic                 illegal_o
);

   localparam int EX_W  = ALUOP_W + 2;
   localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   logic [EX_W-1:0]  dec_ex;
   logic [MEM_W-1:0] dec_mem;
   logic [WB_W-1:0]  dec_wb;
   dec_flags_t       dec_flags;

   control_decode #(.OP_W(OP_W), .ALUOP_W(ALUOP_W)) u_decode (
      .op_i    (op_i),
      .ex_o    (dec_ex),
      .mem_o   (dec_mem),
      .wb_o    (dec_wb),
      .flags_o (dec_flags)
   );

   logic [EX_W-1:0]   idex_ex_q,   idex_ex_d;
   logic [MEM_W-1:0]  idex_mem_q,  idex_mem_d;
   logic [WB_W-1:0]   idex_wb_q,   idex_wb_d;
   logic [REG_AW-1:0] idex_rt_q,   idex_rt_d;
   logic              idex_load_q, idex_load_d;
   logic              idex_mul_q,  idex_mul_d;
   logic [MEM_W-1:0]  exmem_mem_q, exmem_mem_d;
   logic [WB_W-1:0]   exmem_wb_q,  exmem_wb_d;
   logic [WB_W-1:0]   memwb_wb_q,  memwb_wb_d;
   logic [CNT_W-1:0]  mul_cnt_q,   mul_cnt_d;
   logic              illegal_q,   illegal_d;

   logic mul_stall, lu_stall, advance;

   always_comb begin
      mul_stall = (mul_cnt_q != '0) && idex_mul_q;
      lu_stall  = idex_load_q && (idex_rt_q != '0) &&
                  ((idex_rt_q == id_rs_i) || (dec_flags.reads_rt && (idex_rt_q == id_rt_i)));
      advance   = !rst_i && !mul_stall && !lu_stall;

      // A branch seen during a stall is simply re-evaluated once ID is released.
      PC_ctrl_o = 2'b00;
      if (advance) begin
         if (op_i == OP_W'(J_op))
            PC_ctrl_o = 2'b10;
         else if ((op_i == OP_W'(BEQ_op)) && is_equal_i)
            PC_ctrl_o = 2'b11;
      end
      pc_we_o      = advance;
      ifid_we_o    = advance;
      ifid_flush_o = rst_i || PC_ctrl_o[1];
   end

   always_comb begin
      idex_ex_d   = dec_ex;
      idex_mem_d  = dec_mem;
      idex_wb_d   = dec_wb;
      idex_rt_d   = id_rt_i;
      idex_load_d = dec_flags.is_load;
      idex_mul_d  = dec_flags.is_mul;
      exmem_mem_d = idex_mem_q;
      exmem_wb_d  = idex_wb_q;
      memwb_wb_d  = exmem_wb_q;
      mul_cnt_d   = '0;
      illegal_d   = dec_flags.illegal;
      if (mul_stall) begin
         idex_ex_d   = idex_ex_q;
         idex_mem_d  = idex_mem_q;
         idex_wb_d   = idex_wb_q;
         idex_rt_d   = idex_rt_q;
         idex_load_d = idex_load_q;
         idex_mul_d  = idex_mul_q;
         exmem_mem_d = '0;
         exmem_wb_d  = '0;
         mul_cnt_d   = mul_cnt_q - CNT_W'(1);
         illegal_d   = 1'b0;
      end else if (lu_stall) begin
         idex_ex_d   = '0;
         idex_mem_d  = '0;
         idex_wb_d   = '0;
         idex_rt_d   = '0;
         idex_load_d = 1'b0;
         idex_mul_d  = 1'b0;
         illegal_d   = 1'b0;
      end else if (dec_flags.is_mul) begin
         mul_cnt_d   = CNT_W'(MUL_CYCLES - 1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idex_ex_q   <= '0;
         idex_mem_q  <= '0;
         idex_wb_q   <= '0;
         idex_rt_q   <= '0;
         idex_load_q <= 1'b0;
         idex_mul_q  <= 1'b0;
         exmem_mem_q <= '0;
         exmem_wb_q  <= '0;
         memwb_wb_q  <= '0;
         mul_cnt_q   <= '0;
         illegal_q   <= 1'b0;
      end else begin
         idex_ex_q   <= idex_ex_d;
         idex_mem_q  <= idex_mem_d;
         idex_wb_q   <= idex_wb_d;
         idex_rt_q   <= idex_rt_d;
         idex_load_q <= idex_load_d;
         idex_mul_q  <= idex_mul_d;
         exmem_mem_q <= exmem_mem_d;
         exmem_wb_q  <= exmem_wb_d;
         memwb_wb_q  <= memwb_wb_d;
         mul_cnt_q   <= mul_cnt_d;
         illegal_q   <= illegal_d;
      end
   end

   assign EX_ctrl_o  = idex_ex_q;
   assign MEM_ctrl_o = exmem_mem_q;
   assign WB_ctrl_o  = memwb_wb_q;
   assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Random instruction stream against an instruction-flow reference model; a monitor checks all outputs every cycle.
module tb_pipeline_control;
   import mips_ctrl_pkg::*;

   localparam int MUL_CYC = 3;
   localparam int NCYC    = 3000;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op;
   logic [4:0] rs, rt;
   logic       eq;
   logic [1:0] PC_ctrl_o;
   logic       pc_we_o, ifid_we_o, ifid_flush_o, illegal_o;
   logic [4:0] EX_ctrl_o;
   logic [1:0] MEM_ctrl_o, WB_ctrl_o;

   always #5 clk = ~clk;

   pipeline_control #(.OP_W(6), .ALUOP_W(3), .REG_AW(5), .MUL_CYCLES(MUL_CYC)) dut (
      .clk_i(clk), .rst_i(rst), .op_i(op), .id_rs_i(rs), .id_rt_i(rt), .is_equal_i(eq),
      .PC_ctrl_o(PC_ctrl_o), .pc_we_o(pc_we_o), .ifid_we_o(ifid_we_o), .ifid_flush_o(ifid_flush_o),
      .EX_ctrl_o(EX_ctrl_o), .MEM_ctrl_o(MEM_ctrl_o), .WB_ctrl_o(WB_ctrl_o), .illegal_o(illegal_o)
   );

   typedef struct packed { logic bub; logic [5:0] op; logic [4:0] rt; } instr_t;
   typedef struct packed {
      logic [1:0] pc; logic pc_we; logic ifid_we; logic flush;
      logic [4:0] ex; logic [1:0] mem; logic [1:0] wb; logic ill;
   } exp_t;

   localparam instr_t BUB = '{bub: 1'b1, op: 6'h00, rt: 5'h00};

   exp_t   exp_q[$];
   int     n_cmp = 0;
   int     n_fail = 0;
   bit     running = 1'b0;

   // Expected {EX, MEM, WB} of an instruction, straight from the opcode table.
   function automatic logic [8:0] ref_bundle(instr_t i);
      if (i.bub) return '0;
      case (i.op)
         ADD_op:  return {ADD_alu, 2'b01, 2'b00, 2'b11};
         SUB_op:  return {SUB_alu, 2'b01, 2'b00, 2'b11};
         MUL_op:  return {MUL_alu, 2'b01, 2'b00, 2'b11};
         AND_op:  return {AND_alu, 2'b01, 2'b00, 2'b11};
         OR_op:   return {OR_alu,  2'b01, 2'b00, 2'b11};
         ADDI_op: return {ADD_alu, 2'b10, 2'b00, 2'b11};
         LW_op:   return {ADD_alu, 2'b10, 2'b10, 2'b01};
         SW_op:   return {ADD_alu, 2'b10, 2'b11, 2'b00};
         default: return '0;
      endcase
   endfunction

   function automatic bit reads_rt(logic [5:0] o);
      return o inside {ADD_op, SUB_op, MUL_op, AND_op, OR_op, SW_op, BEQ_op};
   endfunction

   function automatic bit defined_op(logic [5:0] o);
      return o inside {ADD_op, SUB_op, MUL_op, AND_op, OR_op, ADDI_op, LW_op, SW_op, J_op, BEQ_op};
   endfunction

   task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("PC_ctrl",  9'(PC_ctrl_o),    9'(e.pc));
            chk("pc_we",    9'(pc_we_o),      9'(e.pc_we));
            chk("ifid_we",  9'(ifid_we_o),    9'(e.ifid_we));
            chk("flush",    9'(ifid_flush_o), 9'(e.flush));
            chk("EX_ctrl",  9'(EX_ctrl_o),    9'(e.ex));
            chk("MEM_ctrl", 9'(MEM_ctrl_o),   9'(e.mem));
            chk("WB_ctrl",  9'(WB_ctrl_o),    9'(e.wb));
            chk("illegal",  9'(illegal_o),    9'(e.ill));
         end else if (running) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_empty at %0t: got 0 entries, expected 1", $time);
         end
      end
   end

   initial begin : driver
      logic [5:0] ops[12];
      logic [4:0] regs[4];
      instr_t ex_s, mem_s, wb_s;
      int     ex_hold;
      bit     ill_s, hold, mul, lu, taken;
      exp_t   e;
      logic [8:0] b;

      ops  = '{ADD_op, SUB_op, MUL_op, AND_op, OR_op, ADDI_op, LW_op, SW_op, J_op, BEQ_op, 6'h3F, 6'h00};
      regs = '{5'd0, 5'd1, 5'd2, 5'd5};
      ex_s = BUB; mem_s = BUB; wb_s = BUB; ex_hold = 0; ill_s = 1'b0; hold = 1'b0;
      rst = 1'b1; op = ADD_op; rs = 5'd1; rt = 5'd2; eq = 1'b0;

      for (int c = 0; c < NCYC; c++) begin
         @(negedge clk);
         if (c < 2) begin
            rst = 1'b1; op = ADD_op; rs = 5'd1; rt = 5'd2;
         end else if (c == 2) begin
            rst = 1'b0; op = ADD_op; rs = 5'd1; rt = 5'd2;
            running = 1'b1;
         end else begin
            rst = ($urandom_range(0, 79) == 0);
            if (!hold) begin
               int k;
               k  = $urandom_range(0, 14);
               op = (k >= 12) ? LW_op : ops[k];
               rs = regs[$urandom_range(0, 3)];
               rt = regs[$urandom_range(0, 3)];
            end
         end
         eq = 1'($urandom_range(0, 1));

         // Reference: instruction flow through EX/MEM/WB with MUL occupancy and load-use interlock.
         mul = (ex_hold > 0);
         lu  = !ex_s.bub && (ex_s.op == LW_op) && (ex_s.rt != 0) &&
               ((ex_s.rt == rs) || (reads_rt(op) && (ex_s.rt == rt)));
         b = ref_bundle(ex_s);   e.ex  = b[8:4];
         b = ref_bundle(mem_s);  e.mem = b[3:2];
         b = ref_bundle(wb_s);   e.wb  = b[1:0];
         e.ill = ill_s;
         if (rst) begin
            e.pc = 2'b00; e.pc_we = 1'b0; e.ifid_we = 1'b0; e.flush = 1'b1;
         end else begin
            taken     = !mul && !lu && ((op == J_op) || ((op == BEQ_op) && eq));
            e.pc      = taken ? ((op == J_op) ? 2'b10 : 2'b11) : 2'b00;
            e.pc_we   = !(mul || lu);
            e.ifid_we = !(mul || lu);
            e.flush   = taken;
         end
         exp_q.push_back(e);

         if (rst) begin
            ex_s = BUB; mem_s = BUB; wb_s = BUB; ex_hold = 0; ill_s = 1'b0; hold = 1'b0;
         end else begin
            wb_s  = mem_s;
            mem_s = mul ? BUB : ex_s;
            ill_s = !mul && !lu && !defined_op(op);
            if (mul) ex_hold--;
            else if (lu) ex_s = BUB;
            else begin
               ex_s    = '{bub: 1'b0, op: op, rt: rt};
               ex_hold = (op == MUL_op) ? MUL_CYC - 1 : 0;
            end
            hold = mul || lu;
         end
      end

      @(negedge clk);
      running = 1'b0;
      #5;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL sb_drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
